// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-port data RAM between the CPU and the video fetcher.
// Grants are combinational; read returns are tagged one cycle later by a small owner FSM.
module mem_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic              CLK_50,
  input  logic              resetN,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              stat_clr,
  output logic [15:0]       cpu_stall_cnt,
  output logic [15:0]       vid_stall_cnt
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  typedef enum logic [1:0] {S_NONE, S_CPU_RD, S_VID_RD} tag_t;

  tag_t        r_tag;
  logic [3:0]  r_vid_wait;
  logic [15:0] r_cpu_stall;
  logic [15:0] r_vid_stall;
  logic        w_vid_win;

  // CPU has priority; video only wins when alone or once it has starved MAX_WAIT cycles.
  assign w_vid_win = vid_req & (~cpu_req | (r_vid_wait == WAIT_MAX));
  assign vid_gnt   = w_vid_win;
  assign cpu_gnt   = cpu_req & ~w_vid_win;

  assign mem_en    = cpu_gnt | vid_gnt;
  assign mem_we    = cpu_gnt & cpu_we;
  assign mem_addr  = cpu_gnt ? cpu_addr : (vid_gnt ? vid_addr : '0);
  assign mem_wdata = cpu_gnt ? cpu_wdata : '0;

  assign cpu_rvalid    = (r_tag == S_CPU_RD);
  assign vid_rvalid    = (r_tag == S_VID_RD);
  assign cpu_rdata     = cpu_rvalid ? mem_rdata : '0;
  assign vid_rdata     = vid_rvalid ? mem_rdata : '0;
  assign cpu_stall_cnt = r_cpu_stall;
  assign vid_stall_cnt = r_vid_stall;

  // Return-tag FSM: records who owns the RAM output on the next cycle.
  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      r_tag <= S_NONE;
    end else begin
      if (vid_gnt)
        r_tag <= S_VID_RD;
      else if (cpu_gnt && !cpu_we)
        r_tag <= S_CPU_RD;
      else
        r_tag <= S_NONE;
    end
  end

  always_ff @(posedge CLK_50 or negedge resetN) begin
    if (!resetN) begin
      r_vid_wait  <= '0;
      r_cpu_stall <= '0;
      r_vid_stall <= '0;
    end else begin
      if (!vid_req || vid_gnt)
        r_vid_wait <= '0;
      else if (r_vid_wait != WAIT_MAX)
        r_vid_wait <= r_vid_wait + 4'd1;

      if (stat_clr) begin
        r_cpu_stall <= '0;
        r_vid_stall <= '0;
      end else begin
        if (cpu_req && !cpu_gnt && r_cpu_stall != 16'hFFFF)
          r_cpu_stall <= r_cpu_stall + 16'd1;
        if (vid_req && !vid_gnt && r_vid_stall != 16'hFFFF)
          r_vid_stall <= r_vid_stall + 16'd1;
      end
    end
  end

endmodule
